// File: rtl/mux_nin_reg_if.sv
// Handshake bundle for mux_nin_reg: N-input data/valid/ready, select and registered output.
// RrMode exists only when MUX_NIN_REG_RR_EN is defined.
interface mux_nin_reg_if #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SELW     = 1
);
    logic [CHANNELS*WIDTH-1:0] In;
    logic [CHANNELS-1:0]       InValid;
    logic [CHANNELS-1:0]       InReady;
    logic [SELW-1:0]           S;
    logic [WIDTH-1:0]          Out;
    logic                      OutValid;
    logic                      OutReady;
    logic [SELW-1:0]           OutChan;
`ifdef MUX_NIN_REG_RR_EN
    logic                      RrMode;
`endif

    modport master (
        output In, InValid, S, OutReady,
`ifdef MUX_NIN_REG_RR_EN
        output RrMode,
`endif
        input  InReady, Out, OutValid, OutChan
    );

    modport slave (
        input  In, InValid, S, OutReady,
`ifdef MUX_NIN_REG_RR_EN
        input  RrMode,
`endif
        output InReady, Out, OutValid, OutChan
    );
endinterface

// File: rtl/mux_nin_reg.sv
// N-input multiplexer into a one-entry zero-bubble output register (fixed select).
// Defining MUX_NIN_REG_RR_EN adds a round-robin mode selected by RrMode.
module mux_nin_reg #(
    parameter int WIDTH    = 16,
    parameter int CHANNELS = 2,
    parameter int SELW     = 1
) (
    input logic          Clk,
    input logic          Rst_n,
    mux_nin_reg_if.slave bus
);

    typedef enum logic {ST_EMPTY = 1'b0, ST_FULL = 1'b1} state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     data_q, data_d;
    logic [SELW-1:0]      chan_q, chan_d;
    logic [SELW-1:0]      sel;
    logic                 sel_ok;
    logic [WIDTH-1:0]     sel_data;
    logic                 sel_valid;
    logic                 can_accept;
    logic                 in_xfer;
    logic                 out_xfer;
    logic [CHANNELS-1:0]  in_ready;
`ifdef MUX_NIN_REG_RR_EN
    logic [SELW-1:0]      ptr_q, ptr_d;
    int unsigned          idx;
`endif

    // Channel selection; an out-of-range select leaves sel_ok low so nothing is picked.
    always_comb begin
        sel    = bus.S;
        sel_ok = (32'(bus.S) < 32'(CHANNELS));
`ifdef MUX_NIN_REG_RR_EN
        idx = 0;
        if (bus.RrMode) begin
            sel    = '0;
            sel_ok = 1'b0;
            for (int unsigned i = 0; i < 32'(CHANNELS); i++) begin
                idx = 32'(ptr_q) + i;
                if (idx >= 32'(CHANNELS)) idx = idx - 32'(CHANNELS);
                for (int unsigned k = 0; k < 32'(CHANNELS); k++) begin
                    if (!sel_ok && (k == idx) && bus.InValid[k]) begin
                        sel_ok = 1'b1;
                        sel    = SELW'(k);
                    end
                end
            end
        end
`endif
    end

    always_comb begin
        can_accept = (state_q == ST_EMPTY) || bus.OutReady;
        sel_data   = '0;
        sel_valid  = 1'b0;
        in_ready   = '0;
        for (int unsigned k = 0; k < 32'(CHANNELS); k++) begin
            if (sel_ok && (32'(sel) == k)) begin
                sel_data    = bus.In[k*WIDTH +: WIDTH];
                sel_valid   = bus.InValid[k];
                in_ready[k] = can_accept;
            end
        end
        in_xfer  = sel_ok && can_accept && sel_valid;
        out_xfer = (state_q == ST_FULL) && bus.OutReady;
    end

    // A simultaneous load and drain keeps the register FULL with the new word.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        chan_d  = chan_q;
        if (in_xfer) begin
            state_d = ST_FULL;
            data_d  = sel_data;
            chan_d  = sel;
        end else if (out_xfer) begin
            state_d = ST_EMPTY;
        end
`ifdef MUX_NIN_REG_RR_EN
        ptr_d = ptr_q;
        if (in_xfer && bus.RrMode) begin
            ptr_d = (32'(sel) == 32'(CHANNELS - 1)) ? '0 : sel + 1'b1;
        end
`endif
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q <= ST_EMPTY;
            data_q  <= '0;
            chan_q  <= '0;
`ifdef MUX_NIN_REG_RR_EN
            ptr_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            chan_q  <= chan_d;
`ifdef MUX_NIN_REG_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    assign bus.InReady  = in_ready;
    assign bus.Out      = data_q;
    assign bus.OutValid = (state_q == ST_FULL);
    assign bus.OutChan  = chan_q;

endmodule
